// File: rtl/frame_pkg.sv
// Shared types and constants for the serial frame engine.
package frame_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } frameState_t;

    localparam logic MSB_FIRST = 1'b0;
    localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/frame_bitcounter.sv
// Frame bit counter: clear, increment, and a terminal flag at WIDTH-1.
module frame_bitcounter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic incr,
    output logic terminal
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/frame_shiftregister.sv
// Full-duplex serial frame engine: configurable width, per-frame bit order,
// separate sample/shift strobes, frame counting and a receive holding register.
module frame_shiftregister
    import frame_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sampleEdge,
    input  logic             shiftEdge,
    input  logic             parallelLoad,
    input  logic             lsbFirst,
    input  logic             abort,
    input  logic [WIDTH-1:0] parallelDataIn,
    input  logic             serialDataIn,
    output logic             serialDataOut,
    output logic [WIDTH-1:0] parallelDataOut,
    output logic [WIDTH-1:0] rxData,
    output logic             busy,
    output logic             frameDone
);

    frameState_t      state;
    logic [WIDTH-1:0] shiftReg;
    logic             sampleFlop;
    logic             orderFlop;
    logic             insBit;
    logic [WIDTH-1:0] nextReg;
    logic             terminal;
    logic             inShift;
    logic             cntClear;
    logic             cntIncr;

    assign inShift = (state == SHIFT);

    // Same-cycle sample and shift bypasses the sample flop.
    always_comb begin
        insBit  = sampleEdge ? serialDataIn : sampleFlop;
        nextReg = shiftReg;
        if (orderFlop == LSB_FIRST) begin
            nextReg = {insBit, shiftReg[WIDTH-1:1]};
        end else begin
            nextReg = {shiftReg[WIDTH-2:0], insBit};
        end
    end

    assign cntClear = parallelLoad || (inShift && (abort || (shiftEdge && terminal)));
    assign cntIncr  = inShift && shiftEdge && !abort && !parallelLoad && !terminal;

    frame_bitcounter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) uBitCounter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cntClear),
        .incr     (cntIncr),
        .terminal (terminal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shiftReg   <= '0;
            rxData     <= '0;
            sampleFlop <= 1'b0;
            orderFlop  <= MSB_FIRST;
            busy       <= 1'b0;
            frameDone  <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            if (parallelLoad) begin
                state     <= SHIFT;
                busy      <= 1'b1;
                shiftReg  <= parallelDataIn;
                orderFlop <= lsbFirst;
            end else if (inShift) begin
                if (abort) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    if (sampleEdge) begin
                        sampleFlop <= serialDataIn;
                    end
                    if (shiftEdge) begin
                        shiftReg <= nextReg;
                        if (terminal) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            rxData    <= nextReg;
                            frameDone <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign serialDataOut   = (orderFlop == LSB_FIRST) ? shiftReg[0] : shiftReg[WIDTH-1];
    assign parallelDataOut = shiftReg;

endmodule

// File: tb/tb_frame_shiftregister.sv
// Directed self-checking bench for frame_shiftregister at WIDTH=8.
module tb_frame_shiftregister;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             sampleEdge;
    logic             shiftEdge;
    logic             parallelLoad;
    logic             lsbFirst;
    logic             abort;
    logic [WIDTH-1:0] parallelDataIn;
    logic             serialDataIn;
    logic             serialDataOut;
    logic [WIDTH-1:0] parallelDataOut;
    logic [WIDTH-1:0] rxData;
    logic             busy;
    logic             frameDone;

    int unsigned checks;
    int unsigned passed;

    frame_shiftregister #(
        .WIDTH (WIDTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sampleEdge      (sampleEdge),
        .shiftEdge       (shiftEdge),
        .parallelLoad    (parallelLoad),
        .lsbFirst        (lsbFirst),
        .abort           (abort),
        .parallelDataIn  (parallelDataIn),
        .serialDataIn    (serialDataIn),
        .serialDataOut   (serialDataOut),
        .parallelDataOut (parallelDataOut),
        .rxData          (rxData),
        .busy            (busy),
        .frameDone       (frameDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic loadWord(input logic [WIDTH-1:0] word, input logic lsb);
        parallelDataIn = word;
        lsbFirst       = lsb;
        parallelLoad   = 1'b1;
        stepCycle();
        parallelLoad   = 1'b0;
    endtask

    task automatic sampleThenShift(input logic b);
        serialDataIn = b;
        sampleEdge   = 1'b1;
        stepCycle();
        sampleEdge   = 1'b0;
        shiftEdge    = 1'b1;
        stepCycle();
        shiftEdge    = 1'b0;
    endtask

    task automatic sampleAndShift(input logic b);
        serialDataIn = b;
        sampleEdge   = 1'b1;
        shiftEdge    = 1'b1;
        stepCycle();
        sampleEdge   = 1'b0;
        shiftEdge    = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] txWord;
        logic [WIDTH-1:0] rxWord;
        checks         = 0;
        passed         = 0;
        rst_n          = 1'b0;
        sampleEdge     = 1'b0;
        shiftEdge      = 1'b0;
        parallelLoad   = 1'b0;
        lsbFirst       = 1'b0;
        abort          = 1'b0;
        parallelDataIn = '0;
        serialDataIn   = 1'b0;
        txWord         = 8'hA5;
        rxWord         = 8'h3C;

        stepCycle();
        stepCycle();
        checkValue("reset_pdo", 32'(parallelDataOut), 32'h0);
        checkValue("reset_rx", 32'(rxData), 32'h0);
        checkValue("reset_busy", 32'(busy), 32'h0);
        checkValue("reset_done", 32'(frameDone), 32'h0);
        checkValue("reset_sdo", 32'(serialDataOut), 32'h0);
        rst_n = 1'b1;
        stepCycle();

        // MSB first: A5 out, 3C in.
        loadWord(8'hA5, 1'b0);
        checkValue("msb_busy", 32'(busy), 32'h1);
        for (int i = 0; i < WIDTH; i++) begin
            checkValue($sformatf("msb_sdo%0d", i), 32'(serialDataOut), 32'(txWord[WIDTH-1-i]));
            sampleThenShift(rxWord[WIDTH-1-i]);
            checkValue($sformatf("msb_done%0d", i), 32'(frameDone), (i == WIDTH-1) ? 32'h1 : 32'h0);
        end
        checkValue("msb_rx", 32'(rxData), 32'h3C);
        checkValue("msb_busy_end", 32'(busy), 32'h0);
        stepCycle();
        checkValue("msb_done_pulse", 32'(frameDone), 32'h0);

        // LSB first: A5 out, 3C in.
        loadWord(8'hA5, 1'b1);
        for (int i = 0; i < WIDTH; i++) begin
            checkValue($sformatf("lsb_sdo%0d", i), 32'(serialDataOut), 32'(txWord[i]));
            sampleThenShift(rxWord[i]);
        end
        checkValue("lsb_done", 32'(frameDone), 32'h1);
        checkValue("lsb_rx", 32'(rxData), 32'h3C);

        // Simultaneous strobes use serialDataIn directly.
        loadWord(8'h00, 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            sampleAndShift(1'b1);
        end
        checkValue("bypass_done", 32'(frameDone), 32'h1);
        checkValue("bypass_rx", 32'(rxData), 32'hFF);

        // Abort after 3 shifts; later strobes must be ignored.
        loadWord(8'h0F, 1'b0);
        for (int i = 0; i < 3; i++) begin
            sampleAndShift(1'b0);
        end
        checkValue("abort_pre", 32'(parallelDataOut), 32'h78);
        abort = 1'b1;
        stepCycle();
        abort = 1'b0;
        checkValue("abort_busy", 32'(busy), 32'h0);
        checkValue("abort_done", 32'(frameDone), 32'h0);
        for (int i = 0; i < 5; i++) begin
            sampleAndShift(1'b1);
            checkValue($sformatf("idle_done%0d", i), 32'(frameDone), 32'h0);
        end
        checkValue("idle_pdo", 32'(parallelDataOut), 32'h78);
        checkValue("idle_rx", 32'(rxData), 32'hFF);
        checkValue("idle_busy", 32'(busy), 32'h0);

        // Load on the completion cycle wins and restarts the count.
        loadWord(8'h00, 1'b0);
        for (int i = 0; i < WIDTH - 1; i++) begin
            sampleAndShift(1'b1);
        end
        checkValue("coll_pre", 32'(parallelDataOut), 32'h7F);
        parallelDataIn = 8'h81;
        parallelLoad   = 1'b1;
        shiftEdge      = 1'b1;
        stepCycle();
        parallelLoad   = 1'b0;
        shiftEdge      = 1'b0;
        checkValue("coll_done", 32'(frameDone), 32'h0);
        checkValue("coll_pdo", 32'(parallelDataOut), 32'h81);
        checkValue("coll_busy", 32'(busy), 32'h1);
        checkValue("coll_rx", 32'(rxData), 32'hFF);
        for (int i = 0; i < WIDTH - 1; i++) begin
            sampleAndShift(1'b0);
        end
        checkValue("coll_cnt_done", 32'(frameDone), 32'h0);
        checkValue("coll_cnt_pdo", 32'(parallelDataOut), 32'h80);
        sampleAndShift(1'b0);
        checkValue("coll_end_done", 32'(frameDone), 32'h1);
        checkValue("coll_end_rx", 32'(rxData), 32'h00);

        // Asynchronous reset mid-frame, between clock edges.
        loadWord(8'hA5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            sampleAndShift(1'b1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkValue("arst_pdo", 32'(parallelDataOut), 32'h0);
        checkValue("arst_rx", 32'(rxData), 32'h0);
        checkValue("arst_busy", 32'(busy), 32'h0);
        checkValue("arst_done", 32'(frameDone), 32'h0);
        checkValue("arst_sdo", 32'(serialDataOut), 32'h0);
        stepCycle();
        #2;
        rst_n = 1'b1;
        stepCycle();
        loadWord(8'hFF, 1'b0);
        checkValue("post_busy", 32'(busy), 32'h1);
        checkValue("post_pdo", 32'(parallelDataOut), 32'hFF);
        checkValue("post_sdo", 32'(serialDataOut), 32'h1);
        for (int i = 0; i < WIDTH - 1; i++) begin
            sampleAndShift(1'b1);
        end
        checkValue("post_early_done", 32'(frameDone), 32'h0);
        sampleAndShift(1'b1);
        checkValue("post_done", 32'(frameDone), 32'h1);
        checkValue("post_rx", 32'(rxData), 32'hFF);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
